tt_um_ieee_demo: RTL and testbench

Iterative Fibonacci calculator packaged as a Tiny Tapeout user tile. The host presents an index n on the dedicated inputs and pulses a start strobe. The block sets busy, iterates one Fibonacci step per clock, then presents F(n) mod 256 on the dedicated outputs. It is the top-level user module of the demo chip.

---
 rtl/tt_um_ieee_demo.sv | 90 +++++++++
 tb/tb_tt_um_ieee_demo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ieee_demo.sv
// Iterative Fibonacci tile: latches index n on a start strobe, performs one
// 8-bit wrapping Fibonacci step per clock, then presents F(n) mod 256.
module tt_um_ieee_demo (
  input  logic       clk,
  input  logic       rst_n,   // active-high asynchronous reset; keeps the tile's pin name
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t     state, state_nx;
  logic [7:0] a, a_nx;
  logic [7:0] b, b_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] res, res_nx;
  logic       stb;
  logic       busy;

  // Tile-select and the upper bidirectional inputs carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:1]};

  assign stb  = uio_in[0];
  assign busy = (state == CALC);

  // Next-state and datapath: accept a start in IDLE, step or finish in CALC.
  always_comb begin
    // NOTE: every next-value defaults to the current register first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    state_nx = state;
    a_nx     = a;
    b_nx     = b;
    cnt_nx   = cnt;
    res_nx   = res;
    case (state)
      IDLE: begin
        if (stb) begin
          a_nx     = 8'd0;
          b_nx     = 8'd1;
          cnt_nx   = ui_in;
          state_nx = CALC;
        end
      end
      CALC: begin
        // stb and ui_in are deliberately not looked at while computing.
        if (cnt == 8'd0) begin
          res_nx   = a;
          state_nx = IDLE;
        end else begin
          a_nx   = b;
          b_nx   = a + b;  // 8-bit sum wraps modulo 256
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      a     <= 8'd0;
      b     <= 8'd1;
      cnt   <= 8'd0;
      res   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values, exactly like the hardware flops they describe.
      state <= state_nx;
      a     <= a_nx;
      b     <= b_nx;
      cnt   <= cnt_nx;
      res   <= res_nx;
    end
  end

  assign uo_out  = res;
  assign uio_out = {6'b0, busy, 1'b0};
  assign uio_oe  = 8'b0000_0010;

endmodule

// File: tb/tb_tt_um_ieee_demo.sv
// Self-checking bench for the Fibonacci tile: table-driven runs plus
// hand-written sequences for reset, ignored inputs and held strobe.
module tb_tt_um_ieee_demo;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  tt_um_ieee_demo dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: straight from the recurrence definition, modulo 256.
  function automatic logic [7:0] fib_ref(input int n);
    int x = 0;
    int y = 1;
    int t;
    for (int i = 0; i < n; i++) begin
      t = (x + y) % 256;
      x = y;
      y = t;
    end
    return x[7:0];
  endfunction

  // One host transaction: 1-cycle strobe, poll busy, read result.
  // With perturb set, stb is pulsed and ui_in changed mid-computation.
  task automatic run_fib(input logic [7:0] n, input logic [7:0] expected,
                         input bit perturb, input string name);
    logic [7:0] prev;
    int         busy_cycles;
    bit         held_ok;
    prev    = uo_out;
    held_ok = 1'b1;
    @(negedge clk);
    ui_in     = n;
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0]   = 1'b0;
    busy_cycles = 0;
    while (uio_out[1] === 1'b1 && busy_cycles < 5000) begin
      busy_cycles++;
      if (uo_out !== prev) held_ok = 1'b0;
      if (perturb && busy_cycles == 3) begin
        uio_in[0] = 1'b1;
        ui_in     = 8'd3;
      end
      if (perturb && busy_cycles == 4) uio_in[0] = 1'b0;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, busy_cycles, n + 1);
    check({name, " result"}, uo_out, expected);
    check({name, " prev_held"}, held_ok, 1'b1);
    @(negedge clk);
    check({name, " no_restart"}, uio_out[1], 1'b0);
  endtask

  initial begin
    int         busy_cycles;
    int         low_cycles;
    logic [7:0] f255;

    vecs[0]  = '{8'd0,  8'd0};
    vecs[1]  = '{8'd1,  8'd1};
    vecs[2]  = '{8'd2,  8'd1};
    vecs[3]  = '{8'd3,  8'd2};
    vecs[4]  = '{8'd4,  8'd3};
    vecs[5]  = '{8'd5,  8'd5};
    vecs[6]  = '{8'd6,  8'd8};
    vecs[7]  = '{8'd7,  8'd13};
    vecs[8]  = '{8'd8,  8'd21};
    vecs[9]  = '{8'd9,  8'd34};
    vecs[10] = '{8'd13, 8'd233};
    vecs[11] = '{8'd14, 8'd121};

    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset uo_out", uo_out, 8'd0);
    check("reset busy", uio_out[1], 1'b0);
    check("reset uio_oe", uio_oe, 8'h02);
    check("reset uio_out_other", {uio_out[7:2], uio_out[0]}, 7'd0);

    // Table-driven runs including the two wrap cases.
    for (int i = 0; i < 12; i++)
      run_fib(vecs[i].n, vecs[i].expected, 1'b0, $sformatf("fib n=%0d", vecs[i].n));

    // Longest computation.
    f255 = fib_ref(255);
    run_fib(8'd255, f255, 1'b0, "fib n=255");

    // Strobe and index changes while busy must be ignored.
    run_fib(8'd9, 8'd34, 1'b1, "ignored_inputs");

    // Reset mid-computation (prior result 34 must be cleared).
    @(negedge clk);
    ui_in     = 8'd20;
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset busy", uio_out[1], 1'b0);
    check("midreset uo_out", uo_out, 8'd0);
    @(negedge clk);
    rst_n = 1'b0;
    run_fib(8'd5, 8'd5, 1'b0, "after_reset n=5");

    // Held strobe: back-to-back runs separated by one idle cycle.
    @(negedge clk);
    ui_in     = 8'd4;
    uio_in[0] = 1'b1;
    @(negedge clk);
    busy_cycles = 0;
    while (uio_out[1] === 1'b1 && busy_cycles < 5000) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("held busy_cycles", busy_cycles, 5);
    check("held result", uo_out, 8'd3);
    low_cycles = 0;
    while (uio_out[1] === 1'b0 && low_cycles < 10) begin
      low_cycles++;
      @(negedge clk);
    end
    check("held idle_gap", low_cycles, 1);
    uio_in[0]   = 1'b0;
    busy_cycles = 1;
    @(negedge clk);
    while (uio_out[1] === 1'b1 && busy_cycles < 5000) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("held second busy_cycles", busy_cycles, 5);
    check("held second result", uo_out, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
